// File: rtl/dmem_responder.sv
// Timed word-organised data memory serving the core's load/store port.
// Each access stalls the core for LAT+1 cycles; reads return data with a one-cycle valid pulse.
module dmem_responder #(
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_read_vd,
    output logic        o_stall,
    output logic        o_busy
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int DEPTH   = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_wdata;
    logic              r_is_wr;
    logic [31:0]       r_read_data;
    logic [31:0]       r_mem [0:DEPTH-1];

    logic w_req;
    logic w_accept;
    logic w_last;
    logic w_unused;

    assign w_req    = i_read_en | i_write_en;
    assign w_accept = (r_state == S_IDLE) && w_req;
    assign w_last   = (r_state == S_BUSY) && (r_cnt == '0);
    // Byte offset and high address bits alias onto the same word.
    assign w_unused = ^{i_addr[31:ADDR_W+2], i_addr[1:0]};

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next     = S_BUSY;
                    w_cnt_next = i_write_en ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Request fields are captured once; the core may change them while stalled.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= i_addr[ADDR_W+1:2];
            r_wdata <= i_write_data;
            r_is_wr <= i_write_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_last && r_is_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_data <= '0;
        end else if (w_last && !r_is_wr) begin
            r_read_data <= r_mem[r_idx];
        end
    end

    assign o_read_data = r_read_data;
    assign o_read_vd   = !rst && (r_state == S_DONE) && !r_is_wr;
    assign o_stall     = !rst && ((r_state == S_BUSY) || w_accept);
    assign o_busy      = (r_state != S_IDLE);

endmodule
